// File: rtl/iq_pair_decay_monitor.sv
// Purpose : de-interleave an I/Q sample stream, compute |I|+|Q|, and run an armed decay watchdog (QUIET/TIMEOUT).
// Latency : pair_stb/i_out/q_out/mag one cycle after the Q sample; status outputs one cycle after that pair_stb.
// Backpr. : none; one sample is accepted every clock and the stream cannot be stalled.
//
// Ports: clk/rst_n (async active-low); iq selects I(0)/Q(1) for sample x; arm restarts the watchdog;
//        thresh/quiet_len/timeout configure it; i_out/q_out/mag/pair_stb carry the last complete pair;
//        busy/quiet/timed_out decode the watchdog state; phase_err is sticky; pair_cnt counts pairs since arm.
// Optional: define IQ_PAIR_PEAK_HOLD_EN to add peak (max mag since arm) and the peak_clr pulse input.
module iq_pair_decay_monitor #(
    parameter int DW = 20,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iq,
    input  logic signed [DW-1:0] x,
    input  logic                 arm,
    input  logic [DW-2:0]        thresh,
    input  logic [CW-1:0]        quiet_len,
    input  logic [CW-1:0]        timeout,
`ifdef IQ_PAIR_PEAK_HOLD_EN
    input  logic                 peak_clr,
    output logic [DW:0]          peak,
`endif
    output logic signed [DW-1:0] i_out,
    output logic signed [DW-1:0] q_out,
    output logic [DW:0]          mag,
    output logic                 pair_stb,
    output logic                 busy,
    output logic                 quiet,
    output logic                 timed_out,
    output logic                 phase_err,
    output logic [CW-1:0]        pair_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_WATCH, S_QUIET, S_TIMEOUT} state_t;

    state_t               state, state_nxt;
    logic signed [DW-1:0] i_hold;
    logic                 pend;
    logic                 pair_in_thr;
    logic [CW-1:0]        run_cnt, run_nxt, cnt_nxt;
    logic [DW-1:0]        abs_i, abs_q;
    logic [DW:0]          mag_nxt;

    // Two's-complement magnitude returned unsigned, so the most negative
    // input maps to 2^(DW-1) exactly instead of wrapping.
    function automatic logic [DW-1:0] abs_dw(input logic [DW-1:0] v);
        return v[DW-1] ? (~v + {{(DW-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    assign abs_i   = abs_dw(i_hold);
    assign abs_q   = abs_dw(x);
    assign mag_nxt = {1'b0, abs_i} + {1'b0, abs_q};

    // Watchdog next-state. arm wins over everything, including a pair
    // strobe in the same cycle, which is then deliberately not counted.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = pair_cnt;
        run_nxt   = run_cnt;
        if (arm) begin
            state_nxt = S_WATCH;
            cnt_nxt   = '0;
            run_nxt   = '0;
        end else if (state == S_WATCH) begin
            if (pair_stb) begin
                cnt_nxt = sat_inc(pair_cnt);
                run_nxt = pair_in_thr ? sat_inc(run_cnt) : '0;
            end
            // Evaluated every cycle so quiet_len==0 exits without a pair;
            // QUIET is checked first so it wins a coincident timeout.
            if (run_nxt >= quiet_len) begin
                state_nxt = S_QUIET;
            end else if (pair_stb && (timeout != '0) && (cnt_nxt >= timeout)) begin
                state_nxt = S_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            i_hold      <= '0;
            pend        <= 1'b0;
            pair_in_thr <= 1'b0;
            run_cnt     <= '0;
            pair_cnt    <= '0;
            i_out       <= '0;
            q_out       <= '0;
            mag         <= '0;
            pair_stb    <= 1'b0;
            busy        <= 1'b0;
            quiet       <= 1'b0;
            timed_out   <= 1'b0;
            phase_err   <= 1'b0;
        end else begin
            pair_stb <= 1'b0;
            if (!iq) begin
                // A repeated I simply replaces the pending one.
                i_hold <= x;
                pend   <= 1'b1;
            end else if (pend) begin
                pend        <= 1'b0;
                i_out       <= i_hold;
                q_out       <= x;
                mag         <= mag_nxt;
                pair_in_thr <= (abs_i <= {1'b0, thresh}) && (abs_q <= {1'b0, thresh});
                pair_stb    <= 1'b1;
            end

            if (arm) begin
                phase_err <= 1'b0;
            end else if (iq && !pend) begin
                phase_err <= 1'b1;
            end

            state     <= state_nxt;
            run_cnt   <= run_nxt;
            pair_cnt  <= cnt_nxt;
            busy      <= (state_nxt == S_WATCH);
            quiet     <= (state_nxt == S_QUIET);
            timed_out <= (state_nxt == S_TIMEOUT);
        end
    end

`ifdef IQ_PAIR_PEAK_HOLD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak <= '0;
        end else if (arm || peak_clr) begin
            peak <= '0;
        end else if (pair_stb && (mag > peak)) begin
            peak <= mag;
        end
    end
`endif

endmodule
